// File: rtl/branch_pc_sequencer.sv
// branch_pc_sequencer
// Owns the fetch PC. Each cycle the next PC is PC+4, the held PC (stall), or a
// taken-branch target computed as BranchPC + (offset << 2). A taken branch that
// resolves while the pipeline is stalled is parked in pend_target_q and applied
// at the first unstalled cycle. The flush/redirect lines are combinational so
// they act on the same edge that loads the new PC.
//
// Ports
//   clk_i            system clock, rising edge
//   rst_ni           asynchronous active-low reset
//   stall_i          load-use hazard: hold PC
//   branch_valid_i   EX stage holds a branch resolving this cycle
//   branch_taken_i   branch condition true (qualified by branch_valid_i)
//   branch_pc_i      PC+4 of the resolving branch
//   branch_offset_i  sign-extended immediate in word units
//   pc_o             current fetch address (registered)
//   pc_plus4_o       pc_o + 4
//   flush_ifid_o     clear IF/ID at the coming edge
//   flush_idex_o     clear ID/EX at the coming edge
//   redirect_o       PC loads a branch target at the coming edge
//   branch_count_o   saturating count of accepted branches
//   taken_count_o    saturating count of accepted taken branches
//   pending_o        debug view of the FSM: 1 while a target is parked
//
// Handshake: branch_valid_i is a one-cycle qualifier with no back-pressure; a
// branch is accepted in the cycle it is presented if the FSM is in RUN, and is
// ignored (wrong path) while PENDING.
module branch_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             branch_valid_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_pc_i,
  input  logic [31:0]      branch_offset_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic             redirect_o,
  output logic [CNT_W-1:0] branch_count_o,
  output logic [CNT_W-1:0] taken_count_o,
  output logic             pending_o
);

  typedef enum logic {
    RUN     = 1'b0,
    PENDING = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_target_q, pend_target_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic [31:0] target;
  logic        accept;
  logic        taken;
  logic        redirect;

  // Word-scaled target; wraps modulo 2^32.
  assign target = branch_pc_i + (branch_offset_i << 2);
  assign accept = (state_q == RUN) && branch_valid_i;
  assign taken  = accept && branch_taken_i;

  // Gated by rst_ni so the lines stay low for the whole reset interval even
  // if the inputs would otherwise request a redirect.
  assign redirect = rst_ni && !stall_i && (taken || (state_q == PENDING));

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    branch_cnt_d  = branch_cnt_q;
    taken_cnt_d   = taken_cnt_q;

    if (state_q == RUN) begin
      if (taken) begin
        if (stall_i) begin
          pend_target_d = target;
          state_d       = PENDING;
        end else begin
          pc_d = target;
        end
      end else if (!stall_i) begin
        pc_d = pc_q + 32'd4;
      end
    end else if (!stall_i) begin
      pc_d    = pend_target_q;
      state_d = RUN;
    end

    // Counters saturate at all-ones.
    if (accept && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + CNT_ONE;
    end
    if (taken && (taken_cnt_q != '1)) begin
      taken_cnt_d = taken_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      pend_target_q <= 32'h0000_0000;
      branch_cnt_q  <= '0;
      taken_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      branch_cnt_q  <= branch_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

  assign pc_o           = pc_q;
  assign pc_plus4_o     = pc_q + 32'd4;
  assign redirect_o     = redirect;
  assign flush_ifid_o   = redirect;
  assign flush_idex_o   = redirect;
  assign branch_count_o = branch_cnt_q;
  assign taken_count_o  = taken_cnt_q;
  assign pending_o      = (state_q == PENDING);

endmodule

// File: tb/tb_branch_pc_sequencer.sv
module tb_branch_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        stall, bv, bt;
  logic [31:0] bpc, boff;

  logic [31:0] pc, pc4;
  logic        fl_ifid, fl_idex, redir, pend;
  logic [15:0] bc, tc;

  logic [31:0] pc_s, pc4_s;
  logic        fl_ifid_s, fl_idex_s, redir_s, pend_s;
  logic [3:0]  bc_s, tc_s;

  branch_pc_sequencer #(.RESET_PC(RESET_PC), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall),
    .branch_valid_i(bv), .branch_taken_i(bt),
    .branch_pc_i(bpc), .branch_offset_i(boff),
    .pc_o(pc), .pc_plus4_o(pc4),
    .flush_ifid_o(fl_ifid), .flush_idex_o(fl_idex), .redirect_o(redir),
    .branch_count_o(bc), .taken_count_o(tc), .pending_o(pend)
  );

  // Narrow-counter instance for saturation checks.
  branch_pc_sequencer #(.RESET_PC(RESET_PC), .CNT_W(4)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall),
    .branch_valid_i(bv), .branch_taken_i(bt),
    .branch_pc_i(bpc), .branch_offset_i(boff),
    .pc_o(pc_s), .pc_plus4_o(pc4_s),
    .flush_ifid_o(fl_ifid_s), .flush_idex_o(fl_idex_s), .redirect_o(redir_s),
    .branch_count_o(bc_s), .taken_count_o(tc_s), .pending_o(pend_s)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the architectural view: fetch PC, whether a taken branch is parked,
  // its target, and unbounded branch counts (saturated when compared).
  logic [31:0] exp_q[$];
  logic [31:0] m_pc, m_pt;
  bit          m_pend;
  int          m_bc, m_tc;

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_pt = 32'h0; m_pend = 0; m_bc = 0; m_tc = 0;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
  endtask

  task automatic model_edge();
    logic [31:0] tgt;
    tgt = bpc + boff * 32'd4;
    if (!m_pend) begin
      if (bv) begin
        m_bc++;
        if (bt) m_tc++;
      end
      if (bv && bt) begin
        if (stall) begin m_pend = 1; m_pt = tgt; end
        else m_pc = tgt;
      end else if (!stall) begin
        m_pc = m_pc + 32'd4;
      end
    end else if (!stall) begin
      m_pc = m_pt;
      m_pend = 0;
    end
    exp_q.delete();
    exp_q.push_back(m_pc);
  endtask

  function automatic bit model_redirect();
    return rst_n && !stall && ((!m_pend && bv && bt) || m_pend);
  endfunction

  task automatic check_model(input string tag);
    logic [31:0] e_pc;
    bit          e_r;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
      return;
    end
    e_pc = exp_q.pop_front();
    e_r  = model_redirect();
    chk({tag, "_pc"},       pc,        e_pc);
    chk({tag, "_pc4"},      pc4,       e_pc + 32'd4);
    chk({tag, "_redirect"}, {31'd0, redir},   {31'd0, e_r});
    chk({tag, "_flush_if"}, {31'd0, fl_ifid}, {31'd0, e_r});
    chk({tag, "_flush_id"}, {31'd0, fl_idex}, {31'd0, e_r});
    chk({tag, "_pending"},  {31'd0, pend},    {31'd0, m_pend});
    chk({tag, "_bc"},       {16'd0, bc},      sat(m_bc, 65535));
    chk({tag, "_tc"},       {16'd0, tc},      sat(m_tc, 65535));
    chk({tag, "_bc_s"},     {28'd0, bc_s},    sat(m_bc, 15));
    chk({tag, "_tc_s"},     {28'd0, tc_s},    sat(m_tc, 15));
    chk({tag, "_pc_s"},     pc_s,      e_pc);
    exp_q.push_back(e_pc);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drive, let combinational outputs settle.
  task automatic drive(input bit s, input bit v, input bit t,
                       input logic [31:0] p, input logic [31:0] o);
    stall = s; bv = v; bt = t; bpc = p; boff = o;
    #2;
  endtask

  // Commit the cycle: rising edge, model update, return at next negedge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Asynchronous reset pulse in the middle of a low clock phase.
  task automatic reset_pulse(input string tag);
    #1 rst_n = 1'b0;
    #1;
    chk({tag, "_rst_pc"},  pc,  RESET_PC);
    chk({tag, "_rst_pnd"}, {31'd0, pend},  32'd0);
    chk({tag, "_rst_red"}, {31'd0, redir}, 32'd0);
    chk({tag, "_rst_bc"},  {16'd0, bc},    32'd0);
    model_reset();
    rst_n = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        stall, bv, bt;
    logic [31:0] bpc, boff;
    logic [31:0] pc;
    logic        redir, pend;
    int          bc, tc;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic s, input logic v, input logic t,
                              input logic [31:0] p, input logic [31:0] o,
                              input logic [31:0] epc, input logic er,
                              input logic ep, input int ebc, input int etc_);
    vec_t r;
    r.stall = s; r.bv = v; r.bt = t; r.bpc = p; r.boff = o;
    r.pc = epc; r.redir = er; r.pend = ep; r.bc = ebc; r.tc = etc_;
    return r;
  endfunction

  initial begin
    // free run from reset
    tbl[0]  = mk(0, 0, 0, 32'h0,         32'h0,         32'h00, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 32'h0,         32'h0,         32'h04, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 32'h0,         32'h0,         32'h08, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 32'h0,         32'h0,         32'h0C, 0, 0, 0, 0);
    // unstalled taken branch, backwards offset -> 0xF0
    tbl[4]  = mk(0, 1, 1, 32'h100,       32'hFFFF_FFFC, 32'h10, 1, 0, 0, 0);
    // taken to 0x40
    tbl[5]  = mk(0, 1, 1, 32'h3C,        32'h1,         32'hF0, 1, 0, 1, 1);
    // not-taken at 0x40
    tbl[6]  = mk(0, 1, 0, 32'h40,        32'h7,         32'h40, 0, 0, 2, 2);
    tbl[7]  = mk(0, 0, 0, 32'h0,         32'h0,         32'h44, 0, 0, 3, 2);
    // taken during stall, target 0x2C; wrong-path branch while pending
    tbl[8]  = mk(1, 1, 1, 32'h20,        32'h3,         32'h48, 0, 0, 3, 2);
    tbl[9]  = mk(1, 1, 1, 32'h500,       32'h0,         32'h48, 0, 1, 4, 3);
    tbl[10] = mk(1, 1, 0, 32'h600,       32'h0,         32'h48, 0, 1, 4, 3);
    tbl[11] = mk(0, 0, 0, 32'h0,         32'h0,         32'h48, 1, 1, 4, 3);
    tbl[12] = mk(0, 0, 0, 32'h0,         32'h0,         32'h2C, 0, 0, 4, 3);
    // wrap-around target
    tbl[13] = mk(0, 1, 1, 32'hFFFF_FFF8, 32'h4,         32'h30, 1, 0, 4, 3);
    tbl[14] = mk(0, 0, 0, 32'h0,         32'h0,         32'h08, 0, 0, 5, 4);
    tbl[15] = mk(0, 0, 0, 32'h0,         32'h0,         32'h0C, 0, 0, 5, 4);
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    stall = 1'b0; bv = 1'b1; bt = 1'b1; bpc = 32'h100; boff = 32'h4;
    model_reset();
    #12;
    // In reset with a taken branch presented: outputs must stay quiet.
    chk("reset_pc",       pc,                 RESET_PC);
    chk("reset_redirect", {31'd0, redir},     32'd0);
    chk("reset_flush_if", {31'd0, fl_ifid},   32'd0);
    chk("reset_flush_id", {31'd0, fl_idex},   32'd0);
    chk("reset_bc",       {16'd0, bc},        32'd0);
    chk("reset_tc",       {16'd0, tc},        32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].stall, tbl[i].bv, tbl[i].bt, tbl[i].bpc, tbl[i].boff);
      chk($sformatf("tbl%0d_pc", i),    pc,               tbl[i].pc);
      chk($sformatf("tbl%0d_red", i),   {31'd0, redir},   {31'd0, tbl[i].redir});
      chk($sformatf("tbl%0d_fif", i),   {31'd0, fl_ifid}, {31'd0, tbl[i].redir});
      chk($sformatf("tbl%0d_fid", i),   {31'd0, fl_idex}, {31'd0, tbl[i].redir});
      chk($sformatf("tbl%0d_pend", i),  {31'd0, pend},    {31'd0, tbl[i].pend});
      chk($sformatf("tbl%0d_bc", i),    {16'd0, bc},      tbl[i].bc);
      chk($sformatf("tbl%0d_tc", i),    {16'd0, tc},      tbl[i].tc);
      check_model($sformatf("tbl%0d_m", i));
      tick();
    end

    // Counter saturation: 20 unstalled taken branches.
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 1, 32'h1000 + 32'(i * 16), 32'h2);
      check_model("sat");
      tick();
    end
    drive(0, 0, 0, 32'h0, 32'h0);
    chk("sat_bc_w4", {28'd0, bc_s}, 32'd15);
    chk("sat_tc_w4", {28'd0, tc_s}, 32'd15);
    chk("sat_bc_w16", {16'd0, bc},  32'd25);
    chk("sat_tc_w16", {16'd0, tc},  32'd24);
    tick();

    // Reset while PENDING discards the parked target.
    drive(1, 1, 1, 32'h200, 32'h8);
    check_model("pr_enter");
    tick();
    drive(1, 0, 0, 32'h0, 32'h0);
    chk("pr_pending", {31'd0, pend}, 32'd1);
    stall = 1'b0;
    reset_pulse("pr");
    tick();
    drive(0, 0, 0, 32'h0, 32'h0);
    chk("pr_after_pc",  pc,             RESET_PC + 32'd4);
    chk("pr_after_red", {31'd0, redir}, 32'd0);
    check_model("pr_after");
    tick();

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] o;
      o = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($signed($urandom_range(0, 64)) - 32);
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom() & 32'hFFFF_FFFC, o);
      check_model("rnd");
      if ($urandom_range(0, 59) == 0) begin
        reset_pulse("rnd");
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/branch_pc_sequencer.md
# branch_pc_sequencer

Program-counter sequencer for the five-stage pipeline: owns the fetch PC register and decides each cycle whether the next PC is PC+4, a held value (stall) or a taken-branch target. The target is word-scaled: resolving-branch PC+4 plus sign-extended offset × 4. It sits between the EX-stage branch resolution and the IF stage. It also drives the IF/ID and ID/EX flush lines, so a taken branch squashes the wrong-path instructions. A taken branch that resolves during a stall is latched and applied when the stall releases.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded on reset
- CNT_W, 16, width of the branch statistics counters
- Clk  in  1  system clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- Stall  in  1  load-use hazard; hold PC, IF/ID not written
- BranchValid  in  1  EX stage holds a branch resolving this cycle
- BranchTaken  in  1  branch condition true; qualified by BranchValid
- BranchPC  in  32  PC+4 of the resolving branch
- BranchOffset  in  32  sign-extended immediate, word units
- PC  out  32  current fetch address (registered)
- PCPlus4  out  32  PC + 4, combinational
- FlushIFID  out  1  clear IF/ID at the coming edge
- FlushIDEX  out  1  clear ID/EX at the coming edge
- Redirect  out  1  PC loads a branch target at the coming edge
- BranchCount  out  CNT_W  branches accepted since reset
- TakenCount  out  CNT_W  taken branches accepted since reset

## Operation
- Target = BranchPC + (BranchOffset << 2), 32-bit, wrap-around modulo 2^32, no overflow flag.
- States: RUN, PENDING. PendTarget is a 32-bit register.
- In RUN, when BranchValid & BranchTaken & !Stall:
  - PC <= target.
  - Redirect, FlushIFID and FlushIDEX are asserted.
  - State stays RUN.
- In RUN, when BranchValid & BranchTaken & Stall:
  - PendTarget <= target, PC held, state -> PENDING.
  - Redirect and both flushes are low this cycle.
- In RUN with no taken branch:
  - Stall: PC held.
  - Otherwise: PC <= PC + 4.
- In PENDING, while Stall: PC held and outputs low. BranchValid is ignored because it is wrong-path; counters do not change.
- In PENDING, once !Stall:
  - PC <= PendTarget.
  - Redirect, FlushIFID and FlushIDEX are asserted.
  - State -> RUN.
- Flush and Redirect outputs are combinational from state and inputs; there are no registered flush pulses.
- Counters change only on BranchValid accepted in RUN, whether or not Stall is high:
  - BranchCount increments on every accepted branch.
  - TakenCount increments when BranchTaken is also high.
  - Both saturate at all-ones and never wrap.
- BranchTaken without BranchValid is ignored.

## Timing
- Reset (Rst_n low, asynchronous):
  - PC = RESET_PC, state = RUN, PendTarget = 0, counters = 0.
  - FlushIFID, FlushIDEX and Redirect are 0 throughout reset.
- First PC advance is at the first rising edge with Rst_n high and Stall low.
- Redirect latency: target visible on PC one cycle after the resolving cycle (unstalled case). In the stalled case it is visible one cycle after the cycle in which Stall deasserts.
- Flushes coincide with Redirect and act at the same edge that loads PC. At most one redirect per edge.
- Stall held N cycles while PENDING: PC is constant for N cycles, then redirects.
- Reset asserted in PENDING: the pending target is discarded and PC = RESET_PC.
- Target wrap: BranchPC = 32'hFFFF_FFF8 with offset 4 gives target 32'h0000_0008.

## Test plan
- Reset then free-run, Stall = 0, no branches, RESET_PC = 0 -> PC reads 0, 4, 8, 12 on consecutive cycles; flushes and Redirect stay 0.
- Taken branch, unstalled: BranchValid = 1, BranchTaken = 1, BranchPC = 0x100, offset = 0xFFFF_FFFC -> Redirect, FlushIFID and FlushIDEX high that cycle; next PC = 0x0F0; BranchCount = 1, TakenCount = 1.
- Not-taken branch: BranchValid = 1, BranchTaken = 0, PC = 0x40 -> next PC = 0x44, no flush; BranchCount increments, TakenCount unchanged.
- Taken branch during Stall (BranchPC = 0x20, offset = 3), Stall high for 3 cycles -> PC constant and outputs low while stalled; an extra BranchValid during PENDING leaves the counters unchanged; on the first unstalled cycle Redirect and flushes are high; next PC = 0x2C.
- Rst_n pulsed low mid-cycle while PENDING -> PC = RESET_PC immediately, state RUN, no redirect after release.
- Counter saturation: CNT_W = 4, 20 taken branches -> BranchCount and TakenCount hold at 15; wrap target case 0xFFFF_FFF8 + 4×4 -> PC = 0x0000_0008.
